ssd_sequence_entry: RTL

//  Parametrised seven-segment sequence display/entry block for the bomb-defuse puzzle panel.

---
 rtl/ssd_seq_pkg.sv | 31 +++
 rtl/ssd_sym_decode.sv | 20 ++
 rtl/ssd_sequence_entry.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ssd_seq_pkg.sv
// Shared glyph table, FSM state type and symbol-code helpers for the
// seven-segment sequence entry block.
package ssd_seq_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = 7'b0100001;

    // Active-low glyphs indexed by symbol number.
    localparam logic [6:0] SEG_GLYPH [0:7] = '{
        7'b1111110, 7'b1111001, 7'b1110111, 7'b1001111,
        7'b1011011, 7'b0110111, 7'b1101101, 7'b0011111
    };

    typedef enum logic {ENTRY, SHOW} state_t;

    // Returns {valid, index} for a one-hot-low code of width w (code zero-extended to 8).
    function automatic logic [3:0] sym_idx(input logic [7:0] code, input int w);
        logic [7:0] mask;
        sym_idx = 4'd0;
        mask    = 8'((9'd1 << w) - 9'd1);
        for (int k = 0; k < 8; k++) begin
            if (k < w && ((code ^ ~(8'd1 << k)) & mask) == 8'd0)
                sym_idx = {1'b1, 3'(k)};
        end
    endfunction

    function automatic logic [7:0] sym_code(input logic [2:0] idx);
        sym_code = ~(8'd1 << idx);
    endfunction

endpackage

// File: rtl/ssd_sym_decode.sv
// Combinational symbol-code to active-low segment glyph decoder; illegal codes
// show the error glyph.
module ssd_sym_decode
    import ssd_seq_pkg::*;
#(
    parameter int SYM_W = 4,
    parameter int SEG_W = 7
) (
    input  logic [SYM_W-1:0] code,
    output logic [SEG_W-1:0] seg
);

    logic [3:0] si;

    always_comb begin
        si  = sym_idx(8'(code), SYM_W);
        seg = si[3] ? SEG_W'(SEG_GLYPH[si[2:0]]) : SEG_W'(SEG_ERR);
    end

endmodule

// File: rtl/ssd_sequence_entry.sv
// Seven-segment sequence display/entry: shows a target sequence, or lets the
// player edit and commit a sequence with Move/Next buttons and a blinking cursor.
module ssd_sequence_entry
    import ssd_seq_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SYM_W      = 4,
    parameter int SEG_W      = 7,
    parameter int BLINK_DIV  = 22
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          display,
    input  logic [NUM_DIGITS*SYM_W-1:0]   seq_in,
    input  logic                          btn_move,
    input  logic                          btn_next,
    output logic [NUM_DIGITS*SYM_W-1:0]   seq_out,
    output logic                          seq_valid,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor,
    output logic [NUM_DIGITS*SEG_W-1:0]   sev_seg
);

    localparam int CUR_W = $clog2(NUM_DIGITS);
    localparam logic [CUR_W-1:0] LAST_DIGIT = CUR_W'(NUM_DIGITS - 1);
    localparam logic [SYM_W-1:0] SYM0 = ~SYM_W'(1);
    localparam logic [NUM_DIGITS*SYM_W-1:0] ENTRY_RST = {NUM_DIGITS{SYM0}};

    state_t                        state_q, state_d;
    logic                          move_prev, next_prev;
    logic                          move_edge, next_edge, in_entry;
    logic [NUM_DIGITS*SYM_W-1:0]   entry_q, entry_d;
    logic [CUR_W-1:0]              cursor_d;
    logic                          commit, cur_chg, blank;
    logic [SYM_W-1:0]              cur_code, adv_code;
    logic [3:0]                    si;
    logic [2:0]                    nidx;
    logic [7:0]                    code8;
    logic [NUM_DIGITS*SYM_W-1:0]   dec_codes;
    logic [NUM_DIGITS*SEG_W-1:0]   dec_segs, sev_d;

    assign move_edge = btn_move & ~move_prev;
    assign next_edge = btn_next & ~next_prev;
    assign in_entry  = (state_q == ENTRY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ENTRY:   if (display)  state_d = SHOW;
            SHOW:    if (!display) state_d = ENTRY;
            default: state_d = ENTRY;
        endcase
    end

    // Move advances the cursor digit; an illegal code recovers to symbol 0.
    always_comb begin
        cur_code = SYM0;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (cursor == CUR_W'(d)) cur_code = entry_q[d*SYM_W +: SYM_W];
        si    = sym_idx(8'(cur_code), SYM_W);
        nidx  = (si[2:0] == 3'(SYM_W - 1)) ? 3'd0 : si[2:0] + 3'd1;
        code8 = si[3] ? sym_code(nidx) : sym_code(3'd0);
        adv_code = code8[SYM_W-1:0];
    end

    always_comb begin
        entry_d  = entry_q;
        cursor_d = cursor;
        commit   = 1'b0;
        cur_chg  = 1'b0;
        if (in_entry && next_edge) begin
            cur_chg = 1'b1;
            if (cursor == LAST_DIGIT) begin
                commit   = 1'b1;
                entry_d  = ENTRY_RST;
                cursor_d = '0;
            end else begin
                cursor_d = cursor + CUR_W'(1);
            end
        end else if (in_entry && move_edge) begin
            for (int d = 0; d < NUM_DIGITS; d++)
                if (cursor == CUR_W'(d)) entry_d[d*SYM_W +: SYM_W] = adv_code;
        end
    end

    generate
        if (BLINK_DIV > 0) begin : g_blink
            logic [BLINK_DIV-1:0] blink_cnt;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)         blink_cnt <= '0;
                else if (in_entry) blink_cnt <= cur_chg ? '0 : blink_cnt + BLINK_DIV'(1);
            end
            assign blank = blink_cnt[BLINK_DIV-1];
        end else begin : g_no_blink
            assign blank = 1'b0;
        end
    endgenerate

    assign dec_codes = in_entry ? entry_q : seq_in;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
        ssd_sym_decode #(.SYM_W(SYM_W), .SEG_W(SEG_W)) u_dec (
            .code (dec_codes[d*SYM_W +: SYM_W]),
            .seg  (dec_segs[d*SEG_W +: SEG_W])
        );
    end

    always_comb begin
        sev_d = dec_segs;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (in_entry && blank && cursor == CUR_W'(d))
                sev_d[d*SEG_W +: SEG_W] = SEG_W'(SEG_BLANK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ENTRY;
            move_prev <= 1'b0;
            next_prev <= 1'b0;
            entry_q   <= ENTRY_RST;
            cursor    <= '0;
            seq_out   <= ENTRY_RST;
            seq_valid <= 1'b0;
            sev_seg   <= '1;
        end else begin
            state_q   <= state_d;
            move_prev <= btn_move;
            next_prev <= btn_next;
            entry_q   <= entry_d;
            cursor    <= cursor_d;
            seq_valid <= commit;
            if (commit) seq_out <= entry_q;
            sev_seg   <= sev_d;
        end
    end

endmodule
